pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//  Owns the architectural PC register, the producer end of the next-PC path: presents PCaddress/PCincre
//  to the next-PC logic and loads the PCnext it returns.
//  Fetches each instruction from instruction memory over a valid/ready request + response handshake.
//  Issues a one-cycle commit strobe per instruction. Parks the core in HALTED on Halt.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  INCR       32'd4          PCincre step; a power of two >= 4
// PORTS
//  clk            in   1   sole clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  PCnext         in   32  next PC from next-PC logic; sampled only on a commit cycle
//  Halt           in   1   halt request from decode; sampled only on a commit cycle
//  imem_req_valid out  1   fetch request valid
//  imem_req_ready in   1   memory accepts the request
//  imem_addr      out  32  fetch address, always equal to PCaddress
//  imem_resp_valid in  1   response data valid; ignored outside WAIT
//  imem_resp_data in   32  instruction word
//  PCaddress      out  32  current PC register
//  PCincre        out  32  PCaddress + INCR, mod 2^32, combinational
//  Instr          out  32  latched instruction for the current PC
//  InstrValid     out  1   commit strobe: Instr is valid and PCnext/Halt are consumed this cycle
//  Halted         out  1   high while in HALTED
//  Misaligned     out  1   high while in MTRAP (MISALIGN_TRAP_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset values: state=FETCH; PCaddress=RESET_PC; Instr=0; InstrValid=0; Halted=0; Misaligned=0.
//   imem_req_valid is asserted in the first cycle after reset.
//  States:
//   FETCH: imem_req_valid=1 and imem_addr=PCaddress, both held stable until imem_req_ready=1.
//          A cycle with valid&ready goes to WAIT.
//   WAIT:  waits for imem_resp_valid. When it is seen, Instr<=imem_resp_data and the next state is EXEC.
//   EXEC:  exactly one cycle, with InstrValid=1. Then:
//          Halt=1 -> PCaddress is unchanged; go to HALTED.
//          else   -> PCaddress<=PCnext; go to FETCH.
//   HALTED: terminal state. No requests; Halted=1; InstrValid=0. Only rst leaves it.
//  Minimum latency, with ready and response both in the next cycle: FETCH->WAIT->EXEC = 3 cycles/instr.
//  Only one request is outstanding at a time; imem_req_valid is never asserted in WAIT, EXEC or HALTED.
//  Responses arrive in order, and the memory is reset by the same rst.
//  Boundary conditions:
//   - imem_resp_valid in FETCH/EXEC/HALTED is ignored.
//   - Response in the same cycle as the request handshake is not accepted: earliest response is the
//     first WAIT cycle.
//   - PC wrap: PCaddress=32'hFFFF_FFFC gives PCincre=32'h0000_0000 with no flag.
//   - PCnext==PCaddress with Halt=0 is a legal self-loop: refetch the same address.
//   - rst in any state, including mid-handshake in FETCH or WAIT: next cycle is the reset values.
//     The pending response is abandoned.
//   - Halt and PCnext are don't-care when InstrValid=0.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - EXEC with Halt=0 and PCnext[1:0]!=2'b00 -> PCaddress is unchanged and the state goes to MTRAP.
//   - MTRAP: terminal, like HALTED, but Misaligned=1 and Halted=1.
//   - Halt=1 has priority over a misaligned PCnext.
//  MISALIGN_TRAP_EN undefined:
//   - PCaddress<=PCnext with bits [1:0] forced to 2'b00.
//   - Misaligned is tied 0; MTRAP does not exist.
// TESTING
//  1 Reset with RESET_PC=32'h100, ready=1, response 1 cycle later with data 32'h00500093, PCnext=32'h104
//    -> imem_addr=32'h100, InstrValid high on cycle 3, Instr=32'h00500093, then imem_addr=32'h104.
//  2 Ready held 0 for 4 cycles in FETCH
//    -> imem_req_valid and imem_addr are stable for all 4 cycles; exactly one request is accepted.
//  3 Commit with Halt=1, PC=32'h200
//    -> Halted=1 and PCaddress=32'h200 persist for 20 cycles; no further imem_req_valid.
//  4 PCaddress=32'hFFFF_FFFC
//    -> PCincre=32'h0; committing PCnext=PCincre fetches address 32'h0.
//  5 rst asserted while in WAIT, then a stale response is sent
//    -> after reset the stale response is ignored; the first fetch is RESET_PC.
//  6 PCnext=32'h00000106 with Halt=0
//    -> with MISALIGN_TRAP_EN: Misaligned=1, PC stays, no fetch.
//    -> without it: next imem_addr=32'h104.

Source files
------------

// File: rtl/pc_fetch.sv
// PC register and instruction fetch sequencer: one outstanding imem request, one commit strobe per
// instruction, terminal HALTED state. Optional MISALIGN_TRAP_EN adds the MTRAP misaligned-target trap.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INCR     = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCnext,
  input  logic        Halt,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] PCaddress,
  output logic [31:0] PCincre,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic        Halted,
  output logic        Misaligned
);

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    EXEC,
    HALTED
`ifdef MISALIGN_TRAP_EN
    , MTRAP
`endif
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        req_valid;
  logic        instr_valid;
  logic        halted;

  assign imem_req_valid = req_valid;
  assign imem_addr      = pc;
  assign PCaddress      = pc;
  assign PCincre        = pc + INCR;
  assign Instr          = instr;
  assign InstrValid     = instr_valid;
  assign Halted         = halted;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign Misaligned = misaligned;
`else
  assign Misaligned = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values and simulation ordering between always blocks cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      req_valid   <= 1'b1;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned  <= 1'b0;
`endif
    end else begin
      // The commit strobe lasts exactly one cycle.
      instr_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (imem_req_ready) begin
            req_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            instr       <= imem_resp_data;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (Halt) begin
            halted <= 1'b1;
            state  <= HALTED;
          end else begin
`ifdef MISALIGN_TRAP_EN
            if (PCnext[1:0] != 2'b00) begin
              halted     <= 1'b1;
              misaligned <= 1'b1;
              state      <= MTRAP;
            end else begin
              pc        <= PCnext;
              req_valid <= 1'b1;
              state     <= FETCH;
            end
`else
            pc        <= {PCnext[31:2], 2'b00};
            req_valid <= 1'b1;
            state     <= FETCH;
`endif
          end
        end
        default: ;  // HALTED / MTRAP: terminal until rst
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: transaction-level model checked every cycle, plus directed
// literal expectations. Honours MISALIGN_TRAP_EN the same way as the design.
module tb_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'h100;
  localparam logic [31:0] INCR     = 32'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCnext;
  logic        Halt;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] PCaddress;
  logic [31:0] PCincre;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        Halted;
  logic        Misaligned;

  pc_fetch #(.RESET_PC(RESET_PC), .INCR(INCR)) dut (
    .clk            (clk),
    .rst            (rst),
    .PCnext         (PCnext),
    .Halt           (Halt),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .PCaddress      (PCaddress),
    .PCincre        (PCincre),
    .Instr          (Instr),
    .InstrValid     (InstrValid),
    .Halted         (Halted),
    .Misaligned     (Misaligned)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int hs_count    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], 16'h0013} ^ 32'h1234_0000;
  endfunction

  // Transaction model: an instruction is requested, then awaited, then committed for one cycle.
  logic        m_init = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_busy, m_commit, m_stopped, m_mis;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1; m_pc = RESET_PC; m_instr = '0;
      m_busy = 1'b0; m_commit = 1'b0; m_stopped = 1'b0; m_mis = 1'b0;
    end else if (m_init) begin
      if (m_stopped) begin
      end else if (m_commit) begin
        m_commit = 1'b0;
        if (Halt) m_stopped = 1'b1;
        else begin
`ifdef MISALIGN_TRAP_EN
          if (PCnext[1:0] != 2'b00) begin m_stopped = 1'b1; m_mis = 1'b1; end
          else m_pc = PCnext;
`else
          m_pc = PCnext & ~32'h3;
`endif
        end
      end else if (m_busy) begin
        if (imem_resp_valid) begin
          m_instr = imem_resp_data; m_busy = 1'b0; m_commit = 1'b1;
        end
      end else if (imem_req_ready) begin
        m_busy = 1'b1;
      end
    end
  end

  always @(posedge clk)
    if (!rst && imem_req_valid && imem_req_ready) hs_count++;

  always @(negedge clk) begin
    if (m_init) begin
      check("pcaddress", PCaddress, m_pc);
      check("pcincre", PCincre, m_pc + INCR);
      check("imem_addr", imem_addr, m_pc);
      check("req_valid", {31'b0, imem_req_valid}, {31'b0, !m_busy && !m_commit && !m_stopped});
      check("instr_valid", {31'b0, InstrValid}, {31'b0, m_commit});
      check("instr", Instr, m_instr);
      check("halted", {31'b0, Halted}, {31'b0, m_stopped});
      check("misaligned", {31'b0, Misaligned}, {31'b0, m_mis});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One full instruction: rdly unready FETCH cycles, sdly empty WAIT cycles, then commit.
  // Responses outside WAIT (including the handshake cycle) carry junk that must be ignored.
  task automatic run_instr(input int rdly, input int sdly, input logic [31:0] nxt, input logic hlt);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0001;
    Halt = 1'b1; PCnext = 32'hDEAD_BEEF; imem_req_ready = 1'b0;
    cyc(rdly);
    imem_req_ready = 1'b1;
    cyc(1);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    cyc(sdly);
    imem_resp_valid = 1'b1; imem_resp_data = mem_word(m_pc);
    cyc(1);
    imem_resp_data = 32'hBAD0_0002; PCnext = nxt; Halt = hlt;
    cyc(1);
    imem_resp_valid = 1'b0; Halt = 1'b1; PCnext = 32'hDEAD_BEEF;
  endtask

  task automatic do_reset;
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  int hs0;

  initial begin
    rst = 1'b1; PCnext = '0; Halt = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    do_reset();

    // Basic fetch from RESET_PC, 3 cycles per instruction.
    check("t1 reset valid", {31'b0, imem_req_valid}, 32'd1);
    check("t1 reset addr", imem_addr, 32'h100);
    check("t1 reset iv", {31'b0, InstrValid}, 32'd0);
    check("t1 reset instr", Instr, 32'h0);
    imem_req_ready = 1'b1;
    cyc(1);
    check("t1 wait valid", {31'b0, imem_req_valid}, 32'd0);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
    cyc(1);
    check("t1 commit iv", {31'b0, InstrValid}, 32'd1);
    check("t1 commit instr", Instr, 32'h0050_0093);
    imem_resp_valid = 1'b0; PCnext = 32'h104; Halt = 1'b0;
    cyc(1);
    check("t1 next addr", imem_addr, 32'h104);
    check("t1 next valid", {31'b0, imem_req_valid}, 32'd1);

    // Self-loop: PCnext equal to the current PC refetches it.
    run_instr(0, 0, 32'h104, 1'b0);
    check("selfloop addr", imem_addr, 32'h104);

    // Backpressure: request held stable for 4 unready cycles, one handshake total.
    hs0 = hs_count;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("t2 hold valid", {31'b0, imem_req_valid}, 32'd1);
      check("t2 hold addr", imem_addr, 32'h104);
    end
    run_instr(0, 2, 32'hFFFF_FFFC, 1'b0);
    check("t2 one handshake", hs_count - hs0, 32'd1);

    // PC wrap.
    check("t4 pcaddress", PCaddress, 32'hFFFF_FFFC);
    check("t4 pcincre", PCincre, 32'h0);
    run_instr(1, 1, 32'h0, 1'b0);
    check("t4 wrapped addr", imem_addr, 32'h0);

    // Misaligned PCnext.
    hs0 = hs_count;
    run_instr(0, 1, 32'h0000_0106, 1'b0);
`ifdef MISALIGN_TRAP_EN
    imem_req_ready = 1'b1;
    cyc(5);
    check("t6 misaligned", {31'b0, Misaligned}, 32'd1);
    check("t6 halted", {31'b0, Halted}, 32'd1);
    check("t6 pc held", PCaddress, 32'h0);
    check("t6 no fetch", {31'b0, imem_req_valid}, 32'd0);
    check("t6 handshakes", hs_count - hs0, 32'd1);
`else
    check("t6 aligned addr", imem_addr, 32'h104);
    check("t6 misaligned", {31'b0, Misaligned}, 32'd0);
`endif

    // Reset while in WAIT; a stale response afterwards is ignored.
    do_reset();
    imem_req_ready = 1'b1;
    cyc(1);
    rst = 1'b1; imem_req_ready = 1'b0;
    cyc(1);
    rst = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0BAD_0BAD;
    cyc(2);
    check("t5 valid", {31'b0, imem_req_valid}, 32'd1);
    check("t5 addr", imem_addr, 32'h100);
    check("t5 instr", Instr, 32'h0);
    check("t5 iv", {31'b0, InstrValid}, 32'd0);
    imem_resp_valid = 1'b0;
    run_instr(0, 0, 32'h200, 1'b0);
    check("t5 next addr", imem_addr, 32'h200);

    // Halt at 0x200: terminal for 20 cycles despite ready/responses.
    hs0 = hs_count;
    run_instr(1, 0, 32'h300, 1'b1);
    hs0 = hs_count;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      imem_resp_valid = i[0];
      cyc(1);
      check("t3 halted", {31'b0, Halted}, 32'd1);
      check("t3 pc", PCaddress, 32'h200);
      check("t3 no req", {31'b0, imem_req_valid}, 32'd0);
    end
    check("t3 handshakes", hs_count - hs0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
